mem_arbiter: RTL and testbench

- Owns the single byte-wide RAM port and shares it between two requesters: the instruction-fetch path (icache line fill feeding ifetch) and the load/store buffer (LSB).
- Sequences multi-byte transfers one byte per cycle, assembles read data little-endian, and returns a one-cycle done pulse to the granted requester.
- Arbitrates round-robin, aborts speculative reads on flush, and stalls IO stores while the IO buffer is full.

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the byte-wide RAM port arbiter.
//   - ARB_* : arbiter FSM state encodings
//   - LEN_* : LSB access-length codes
//   - IO_ADDR_HI : addr[17:16] value that selects the memory-mapped IO window
//   - ADDR_WIDTH : default address width
//   - len_bytes() : LEN code to byte count
package mem_arbiter_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_IFETCH = 2'd1;
  localparam logic [1:0] ARB_DREAD  = 2'd2;
  localparam logic [1:0] ARB_DWRITE = 2'd3;

  localparam logic [1:0] LEN_B = 2'b00;
  localparam logic [1:0] LEN_H = 2'b01;
  localparam logic [1:0] LEN_W = 2'b10;

  localparam logic [1:0] IO_ADDR_HI = 2'b11;

  // The illegal code 2'b11 falls back to a word access.
  function automatic logic [4:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_B:   return 5'd1;
      LEN_H:   return 5'd2;
      LEN_W:   return 5'd4;
      default: return 5'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM port between the icache line fill and the
// load/store buffer. Transfers are sequenced one byte per cycle, read data is
// assembled little-endian, and the granted side gets a one-cycle done pulse.
// Ports:
//   clk, rst_in (async, active-high), rdy_in (global enable)
//   flush            : aborts in-flight reads, blocks new speculative reads
//   io_buffer_full   : stalls stores into the IO window
//   ic_req_*/ic_*    : icache fill request / done pulse / line data
//   lsb_req_*/lsb_*  : load/store request / done pulse / load data
//   mem_din/mem_dout/mem_a/mem_wr : RAM port
module mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = mem_arbiter_pkg::ADDR_WIDTH,
  parameter int unsigned LINE_BYTES = 4
) (
  input  logic                    clk,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    flush,
  input  logic                    io_buffer_full,
  input  logic                    ic_req_valid,
  input  logic [ADDR_WIDTH-1:0]   ic_req_addr,
  output logic                    ic_done,
  output logic [8*LINE_BYTES-1:0] ic_rdata,
  input  logic                    lsb_req_valid,
  input  logic                    lsb_req_wr,
  input  logic [ADDR_WIDTH-1:0]   lsb_req_addr,
  input  logic [1:0]              lsb_req_len,
  input  logic [31:0]             lsb_req_wdata,
  output logic                    lsb_done,
  output logic [31:0]             lsb_rdata,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_WIDTH-1:0]   mem_a,
  output logic                    mem_wr
);
  import mem_arbiter_pkg::*;

  localparam int unsigned BufW = 8 * LINE_BYTES;
  localparam logic GntIc  = 1'b0;
  localparam logic GntLsb = 1'b1;

  logic [1:0]            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [4:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] mem_a_q, mem_a_d;
  logic [7:0]            mem_dout_q, mem_dout_d;
  logic                  mem_wr_q, mem_wr_d;
  logic                  ic_done_q, ic_done_d;
  logic                  lsb_done_q, lsb_done_d;
  logic [BufW-1:0]       ic_rdata_q, ic_rdata_d;
  logic [31:0]           lsb_rdata_q, lsb_rdata_d;
  logic [BufW-1:0]       buf_q, buf_d, buf_ins;
  logic [31:0]           wdata_q, wdata_d, wdata_sh;

  logic                  cand_ic, cand_lsb, grant_ic, grant_lsb;
  logic                  last_byte;
  logic [ADDR_WIDTH-1:0] a_nxt;

  // Flush blocks speculative reads; committed stores may still be granted.
  assign cand_ic   = ic_req_valid && !flush;
  assign cand_lsb  = lsb_req_valid && (!flush || lsb_req_wr);
  assign grant_lsb = cand_lsb && !(cand_ic && last_grant_q == GntLsb);
  assign grant_ic  = cand_ic && !grant_lsb;

  assign last_byte = (cnt_q == n_q - 5'd1);
  assign a_nxt     = mem_a_q + ADDR_WIDTH'(1);

  // Current read byte merged into the assembly buffer at index cnt_q.
  always_comb begin
    buf_ins = buf_q;
    for (int i = 0; i < int'(LINE_BYTES); i++) begin
      if (cnt_q == 5'(i)) buf_ins[8*i +: 8] = mem_din;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    mem_a_d      = mem_a_q;
    mem_dout_d   = mem_dout_q;
    mem_wr_d     = mem_wr_q;
    ic_done_d    = 1'b0;
    lsb_done_d   = 1'b0;
    ic_rdata_d   = ic_rdata_q;
    lsb_rdata_d  = lsb_rdata_q;
    buf_d        = buf_q;
    wdata_d      = wdata_q;
    wdata_sh     = '0;

    case (state_q)
      ARB_IDLE: begin
        if (grant_ic || grant_lsb) begin
          cnt_d        = '0;
          buf_d        = '0;  // unfilled bytes read back as zero
          last_grant_d = grant_lsb ? GntLsb : GntIc;
          if (grant_ic) begin
            state_d = ARB_IFETCH;
            mem_a_d = ic_req_addr;
            n_d     = 5'(LINE_BYTES);
          end else begin
            mem_a_d = lsb_req_addr;
            n_d     = len_bytes(lsb_req_len);
            wdata_d = lsb_req_wdata;
            if (lsb_req_wr) begin
              state_d    = ARB_DWRITE;
              mem_dout_d = lsb_req_wdata[7:0];
              mem_wr_d   = !(lsb_req_addr[17:16] == IO_ADDR_HI && io_buffer_full);
            end else begin
              state_d = ARB_DREAD;
            end
          end
        end
      end

      ARB_IFETCH, ARB_DREAD: begin
        if (flush) begin
          state_d = ARB_IDLE;
          mem_a_d = '0;
        end else begin
          buf_d = buf_ins;
          if (last_byte) begin
            state_d = ARB_IDLE;
            mem_a_d = '0;
            if (state_q == ARB_IFETCH) begin
              ic_done_d  = 1'b1;
              ic_rdata_d = buf_ins;
            end else begin
              lsb_done_d  = 1'b1;
              lsb_rdata_d = buf_ins[31:0];
            end
          end else begin
            mem_a_d = a_nxt;
            cnt_d   = cnt_q + 5'd1;
          end
        end
      end

      ARB_DWRITE: begin
        // A byte presented with mem_wr high is written at this edge, so only
        // then does the transfer advance; a stalled byte is re-issued later.
        if (mem_wr_q) begin
          if (last_byte) begin
            state_d    = ARB_IDLE;
            mem_a_d    = '0;
            mem_wr_d   = 1'b0;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d      = cnt_q + 5'd1;
            mem_a_d    = a_nxt;
            wdata_sh   = wdata_q >> {cnt_d[1:0], 3'b000};
            mem_dout_d = wdata_sh[7:0];
            mem_wr_d   = !(a_nxt[17:16] == IO_ADDR_HI && io_buffer_full);
          end
        end else begin
          mem_wr_d = !(mem_a_q[17:16] == IO_ADDR_HI && io_buffer_full);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_in) begin
    if (rst_in) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GntIc;
      cnt_q        <= '0;
      n_q          <= '0;
      mem_a_q      <= '0;
      mem_dout_q   <= '0;
      mem_wr_q     <= 1'b0;
      ic_done_q    <= 1'b0;
      lsb_done_q   <= 1'b0;
      ic_rdata_q   <= '0;
      lsb_rdata_q  <= '0;
      buf_q        <= '0;
      wdata_q      <= '0;
    end else if (rdy_in) begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      mem_a_q      <= mem_a_d;
      mem_dout_q   <= mem_dout_d;
      mem_wr_q     <= mem_wr_d;
      ic_done_q    <= ic_done_d;
      lsb_done_q   <= lsb_done_d;
      ic_rdata_q   <= ic_rdata_d;
      lsb_rdata_q  <= lsb_rdata_d;
      buf_q        <= buf_d;
      wdata_q      <= wdata_d;
    end
  end

  assign mem_a     = mem_a_q;
  assign mem_dout  = mem_dout_q;
  assign mem_wr    = mem_wr_q && rdy_in;  // frozen cycles must not write
  assign ic_done   = ic_done_q;
  assign ic_rdata  = ic_rdata_q;
  assign lsb_done  = lsb_done_q;
  assign lsb_rdata = lsb_rdata_q;

  // Requesters hold valid for the whole transfer (flush may drop a read).
  ic_hold_a: assert property (@(posedge clk) disable iff (rst_in)
      (state_q == ARB_IFETCH && !flush) |-> ic_req_valid);
  lsb_hold_a: assert property (@(posedge clk) disable iff (rst_in)
      ((state_q == ARB_DREAD && !flush) || state_q == ARB_DWRITE) |-> lsb_req_valid);

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned LB = 4;

  logic          clk = 1'b0;
  logic          rst_in, rdy_in, flush, io_buffer_full;
  logic          ic_req_valid;
  logic [AW-1:0] ic_req_addr;
  logic          ic_done;
  logic [8*LB-1:0] ic_rdata;
  logic          lsb_req_valid, lsb_req_wr;
  logic [AW-1:0] lsb_req_addr;
  logic [1:0]    lsb_req_len;
  logic [31:0]   lsb_req_wdata;
  logic          lsb_done;
  logic [31:0]   lsb_rdata;
  logic [7:0]    mem_din, mem_dout;
  logic [AW-1:0] mem_a;
  logic          mem_wr;

  mem_arbiter #(.ADDR_WIDTH(AW), .LINE_BYTES(LB)) dut (
    .clk(clk), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .io_buffer_full(io_buffer_full),
    .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr),
    .ic_done(ic_done), .ic_rdata(ic_rdata),
    .lsb_req_valid(lsb_req_valid), .lsb_req_wr(lsb_req_wr),
    .lsb_req_addr(lsb_req_addr), .lsb_req_len(lsb_req_len),
    .lsb_req_wdata(lsb_req_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // RAM model: combinational read of the registered address (one-cycle
  // latency from the issuing edge); writes land at the clock edge.
  logic [7:0] ram     [0:4095];
  bit         written [0:4095];
  int unsigned wlog_a[$];
  logic [7:0]  wlog_d[$];
  int ic_done_cnt = 0;
  int lsb_done_cnt = 0;

  function automatic logic [7:0] init_byte(input logic [11:0] a);
    case (a)
      12'h100: return 8'h13;
      12'h101: return 8'h05;
      12'h200: return 8'hAB;
      12'h201: return 8'hCD;
      12'h040: return 8'h11;
      12'h041: return 8'h22;
      12'h042: return 8'h33;
      12'h043: return 8'h44;
      12'h044: return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  always_comb begin
    mem_din = written[mem_a[11:0]] ? ram[mem_a[11:0]] : init_byte(mem_a[11:0]);
  end

  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a[11:0]]     = mem_dout;
      written[mem_a[11:0]] = 1'b1;
      wlog_a.push_back(mem_a);
      wlog_d.push_back(mem_dout);
    end
    if (ic_done) ic_done_cnt++;
    if (lsb_done) lsb_done_cnt++;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until the selected done pulse is visible, bounded.
  task automatic wait_done(input bit is_ic, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!(is_ic ? ic_done : lsb_done) && n < 40);
  endtask

  task automatic lsb_req(input bit wr, input logic [31:0] a, input logic [1:0] len,
                         input logic [31:0] wd);
    lsb_req_valid = 1'b1;
    lsb_req_wr    = wr;
    lsb_req_addr  = a;
    lsb_req_len   = len;
    lsb_req_wdata = wd;
  endtask

  typedef struct {
    bit          is_ic;
    bit          wr;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cycles;  // request set to done visible = N + 1
  } vec_t;

  vec_t vecs [10];

  initial begin : main
    int n;
    int base_cnt;

    vecs[0] = '{1'b1, 1'b0, 32'h100, 2'b10, 32'h0,        32'h00000513, 5};
    vecs[1] = '{1'b0, 1'b0, 32'h200, 2'b01, 32'h0,        32'h0000CDAB, 3};
    vecs[2] = '{1'b0, 1'b0, 32'h201, 2'b00, 32'h0,        32'h000000CD, 2};
    vecs[3] = '{1'b0, 1'b0, 32'h040, 2'b10, 32'h0,        32'h44332211, 5};
    vecs[4] = '{1'b0, 1'b1, 32'h050, 2'b01, 32'h1234BEEF, 32'h0,        3};
    vecs[5] = '{1'b0, 1'b0, 32'h050, 2'b10, 32'h0,        32'h0000BEEF, 5};
    vecs[6] = '{1'b0, 1'b0, 32'h041, 2'b10, 32'h0,        32'h55443322, 5};
    vecs[7] = '{1'b1, 1'b0, 32'h040, 2'b10, 32'h0,        32'h44332211, 5};
    vecs[8] = '{1'b0, 1'b1, 32'h052, 2'b00, 32'h000000AA, 32'h0,        2};
    vecs[9] = '{1'b0, 1'b0, 32'h050, 2'b10, 32'h0,        32'h00AABEEF, 5};

    rst_in = 1'b1; rdy_in = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
    ic_req_valid = 1'b0; ic_req_addr = '0;
    lsb_req_valid = 1'b0; lsb_req_wr = 1'b0; lsb_req_addr = '0;
    lsb_req_len = 2'b00; lsb_req_wdata = '0;
    tick(); tick();

    // Reset state
    chk("rst mem_a", mem_a, 32'h0);
    chk("rst mem_dout", 32'(mem_dout), 32'h0);
    chk("rst mem_wr", 32'(mem_wr), 32'h0);
    chk("rst ic_done", 32'(ic_done), 32'h0);
    chk("rst lsb_done", 32'(lsb_done), 32'h0);
    chk("rst ic_rdata", ic_rdata, 32'h0);
    chk("rst lsb_rdata", lsb_rdata, 32'h0);
    rst_in = 1'b0;
    tick();
    chk("idle mem_a", mem_a, 32'h0);

    // IC fill address sequence
    ic_req_valid = 1'b1; ic_req_addr = 32'h100;
    tick(); chk("fill a0", mem_a, 32'h100);
    tick(); chk("fill a1", mem_a, 32'h101);
    tick(); chk("fill a2", mem_a, 32'h102);
    tick(); chk("fill a3", mem_a, 32'h103);
    chk("fill early done", 32'(ic_done), 32'h0);
    tick();
    chk("fill done", 32'(ic_done), 32'h1);
    chk("fill rdata", ic_rdata, 32'h00000513);
    chk("fill mem_a back to 0", mem_a, 32'h0);
    ic_req_valid = 1'b0;
    tick();
    chk("fill done one cycle", 32'(ic_done), 32'h0);

    // Table-driven transactions
    for (int i = 0; i < 10; i++) begin
      if (vecs[i].is_ic) begin
        ic_req_valid = 1'b1;
        ic_req_addr  = vecs[i].addr;
      end else begin
        lsb_req(vecs[i].wr, vecs[i].addr, vecs[i].len, vecs[i].wdata);
      end
      wait_done(vecs[i].is_ic, n);
      ic_req_valid  = 1'b0;
      lsb_req_valid = 1'b0;
      chk($sformatf("vec%0d latency", i), n, vecs[i].exp_cycles);
      if (vecs[i].is_ic)
        chk($sformatf("vec%0d ic_rdata", i), ic_rdata, vecs[i].exp_rdata);
      else if (!vecs[i].wr)
        chk($sformatf("vec%0d lsb_rdata", i), lsb_rdata, vecs[i].exp_rdata);
      tick();
    end

    // Round-robin after reset: last_grant = IC, so LSB wins first
    rst_in = 1'b1; tick(); rst_in = 1'b0; tick();
    ic_req_valid = 1'b1; ic_req_addr = 32'h100;
    lsb_req(1'b0, 32'h200, 2'b01, 32'h0);
    tick(); chk("rr1 lsb first", mem_a, 32'h200);
    tick(); chk("rr1 lsb a1", mem_a, 32'h201);
    tick();
    chk("rr1 lsb done", 32'(lsb_done), 32'h1);
    chk("rr1 lsb rdata", lsb_rdata, 32'h0000CDAB);
    lsb_req_valid = 1'b0;
    tick(); chk("rr1 ic next edge", mem_a, 32'h100);
    tick(); tick(); tick(); tick();
    chk("rr1 ic done", 32'(ic_done), 32'h1);
    chk("rr1 ic rdata", ic_rdata, 32'h00000513);
    ic_req_valid = 1'b0;
    tick();
    ic_req_valid = 1'b1;
    lsb_req(1'b0, 32'h200, 2'b01, 32'h0);
    tick(); chk("rr2 lsb wins", mem_a, 32'h200);
    wait_done(1'b0, n);
    chk("rr2 lsb latency", n, 2);
    lsb_req_valid = 1'b0;
    wait_done(1'b1, n);
    chk("rr2 ic latency", n, 5);
    ic_req_valid = 1'b0;
    tick();

    // IO stall: store into IO window with buffer full for 3 cycles
    wlog_a.delete(); wlog_d.delete();
    base_cnt = lsb_done_cnt;
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h30000, 2'b10, 32'hDEADBEEF);
    tick(); chk("io stall0 wr", 32'(mem_wr), 32'h0);
    chk("io stall0 a", mem_a, 32'h30000);
    tick(); chk("io stall1 wr", 32'(mem_wr), 32'h0);
    tick(); chk("io stall2 wr", 32'(mem_wr), 32'h0);
    io_buffer_full = 1'b0;
    tick(); chk("io resume wr", 32'(mem_wr), 32'h1);
    chk("io resume dout", 32'(mem_dout), 32'hEF);
    wait_done(1'b0, n);
    chk("io latency after resume", n, 4);
    lsb_req_valid = 1'b0;
    tick(); tick();
    chk("io done count", lsb_done_cnt - base_cnt, 1);
    chk("io write count", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] ev;
        ev = 32'hDEADBEEF >> (8 * i);
        chk($sformatf("io wr%0d addr", i), wlog_a[i], 32'h30000 + 32'(i));
        chk($sformatf("io wr%0d data", i), 32'(wlog_d[i]), 32'(ev[7:0]));
      end
    end

    // Flush two cycles into IFETCH
    base_cnt = ic_done_cnt;
    ic_req_valid = 1'b1; ic_req_addr = 32'h040;
    tick(); tick();
    flush = 1'b1; ic_req_valid = 1'b0;
    tick();
    chk("flush ifetch idle", mem_a, 32'h0);
    chk("flush ifetch no done", 32'(ic_done), 32'h0);
    flush = 1'b0;
    tick(); tick();
    chk("flush ifetch done cnt", ic_done_cnt - base_cnt, 0);
    chk("flush ifetch rdata kept", ic_rdata, 32'h00000513);

    // Flush in IDLE: load excluded, store still granted
    flush = 1'b1;
    lsb_req(1'b0, 32'h200, 2'b00, 32'h0);
    tick(); chk("flush blocks load", mem_a, 32'h0);
    lsb_req(1'b1, 32'h074, 2'b00, 32'h11);
    tick(); chk("flush allows store", 32'(mem_wr), 32'h1);
    flush = 1'b0;
    wait_done(1'b0, n);
    chk("flush store latency", n, 1);
    lsb_req_valid = 1'b0;
    tick();

    // Flush during a 4B store (non-IO address, so io_buffer_full is ignored)
    wlog_a.delete(); wlog_d.delete();
    base_cnt = lsb_done_cnt;
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 32'h060, 2'b10, 32'hCAFEF00D);
    tick(); tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    wait_done(1'b0, n);
    chk("flush store remaining", n, 2);
    lsb_req_valid = 1'b0;
    io_buffer_full = 1'b0;
    tick();
    chk("flush store done cnt", lsb_done_cnt - base_cnt, 1);
    chk("flush store wr count", wlog_a.size(), 4);
    if (wlog_a.size() == 4) begin
      chk("flush store b0", 32'(wlog_d[0]), 32'h0D);
      chk("flush store b3", 32'(wlog_d[3]), 32'hCA);
      chk("flush store a3", wlog_a[3], 32'h063);
    end

    // rdy_in low for 5 cycles mid-read
    lsb_req(1'b0, 32'h040, 2'b10, 32'h0);
    tick(); tick();
    chk("rdy pre a", mem_a, 32'h041);
    rdy_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("rdy hold a%0d", i), mem_a, 32'h041);
    end
    rdy_in = 1'b1;
    wait_done(1'b0, n);
    chk("rdy remaining latency", n, 3);
    chk("rdy rdata", lsb_rdata, 32'h44332211);
    lsb_req_valid = 1'b0;
    tick();

    // rdy_in gates mem_wr combinationally
    wlog_a.delete(); wlog_d.delete();
    lsb_req(1'b1, 32'h070, 2'b00, 32'h0000005A);
    tick(); chk("gate wr on", 32'(mem_wr), 32'h1);
    rdy_in = 1'b0;
    #1 chk("gate wr forced 0", 32'(mem_wr), 32'h0);
    tick();
    rdy_in = 1'b1;
    #1 chk("gate wr reissued", 32'(mem_wr), 32'h1);
    wait_done(1'b0, n);
    chk("gate latency", n, 1);
    lsb_req_valid = 1'b0;
    tick();
    chk("gate single write", wlog_a.size(), 1);
    if (wlog_a.size() == 1) chk("gate write data", 32'(wlog_d[0]), 32'h5A);

    // Async reset mid-IFETCH
    base_cnt = ic_done_cnt;
    ic_req_valid = 1'b1; ic_req_addr = 32'h100;
    tick(); tick();
    rst_in = 1'b1;
    #1;
    chk("rst mid mem_a", mem_a, 32'h0);
    chk("rst mid ic_done", 32'(ic_done), 32'h0);
    chk("rst mid ic_rdata", ic_rdata, 32'h0);
    ic_req_valid = 1'b0;
    tick();
    rst_in = 1'b0;
    tick(); tick(); tick();
    chk("rst mid no done", ic_done_cnt - base_cnt, 0);
    chk("rst mid idle", mem_a, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
